window_line_ctrl: RTL
=====================

Name: window_line_ctrl

Overview:
Parametrised successor of the 3x3 line-buffer controller. Stores NUM_BUF = KSIZE+1 rotating line buffers of LINE_W pixels each and emits a KSIZE x KSIZE pixel window per output beat for downstream convolution/filter blocks. It adds ready/valid backpressure on both sides, right-edge zero padding, and a registered end-of-line interrupt. It sits between the pixel input stream and the filter datapath.

Parameters:
PIXEL_W, 8, bits per pixel
LINE_W, 512, pixels per image line; must be >= KSIZE
KSIZE, 3, window size (rows and columns); must be >= 2; NUM_BUF = KSIZE+1 is derived, not overridable

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_data  input  PIXEL_W  input pixel
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a pixel
out_window  output  KSIZE*KSIZE*PIXEL_W  window data
out_valid  output  1  out_window valid
out_ready  input  1  downstream accepts the window
out_line_done  output  1  one-cycle pulse after the last window of an output line is accepted
lines_full  output  clog2(NUM_BUF+1)  number of complete, unconsumed lines held

Behaviour:
- Reset: wr_buf, wr_col, rd_buf, rd_col and lines_full are 0; FSM is IDLE; out_valid=0; out_line_done=0. in_ready is 1 in the first cycle after reset. Buffer contents are not cleared. Reset mid-operation discards every partial or complete line.
- Input accept: in_valid && in_ready. in_ready = (lines_full < NUM_BUF), decoded from registers only. There is no combinational path from out_ready to in_ready.
- On accept, in_data is written to buffer[wr_buf][wr_col] and wr_col increments. At wr_col == LINE_W-1: wr_col wraps to 0, wr_buf increments modulo NUM_BUF, and a line-complete event fires.
- FSM states are IDLE and READ. out_valid = (state == READ).
  - IDLE -> READ when the registered lines_full >= KSIZE.
  - READ holds while rd_col < LINE_W-1, or while out_ready is low.
- Output accept: out_valid && out_ready, which increments rd_col. On the accept at rd_col == LINE_W-1:
  - rd_col wraps to 0 and rd_buf increments modulo NUM_BUF.
  - A line-consumed event fires, and out_line_done=1 on the next cycle.
  - The next state is READ if lines_full_next >= KSIZE, otherwise IDLE. Back-to-back lines run with no bubble.
- lines_full_next = lines_full + line_complete - line_consumed. Simultaneous events leave it unchanged. It never exceeds NUM_BUF and never underflows.
- Window element (r,j), with r = 0..KSIZE-1 and j = 0..KSIZE-1:
  - Value is pixel at column rd_col+j of buffer (rd_buf+r) mod NUM_BUF. r=0 is the oldest line.
  - If rd_col+j >= LINE_W the element is 0 (right-edge zero pad; no wrap).
  - Placement: bits [(KSIZE*KSIZE-1-(r*KSIZE+j))*PIXEL_W +: PIXEL_W]. Element (0,0) is in the MSBs.
- Window timing:
  - out_window is a combinational read of storage at the registered rd_buf/rd_col, so data appears in the same cycle as out_valid.
  - out_window is stable while out_valid && !out_ready.
  - The write buffer is never one of the KSIZE buffers being read: the in_ready rule guarantees this.
- Latency: a line completing at cycle t raises lines_full at t+1. If that makes lines_full >= KSIZE, out_valid is asserted at t+2.
- Arithmetic: column counters are clog2(LINE_W) bits with explicit compare-and-wrap, so a non-power-of-2 LINE_W is legal. Buffer indices wrap explicitly at NUM_BUF.

Test Plan:
Common setup: LINE_W=8, KSIZE=3, PIXEL_W=8. Stimulus pixel value = 8*line+col.
1. Fill: after reset, stream 24 pixels with out_ready=0 -> out_valid stays 0 through the 24th accept. out_valid=1 two cycles later with rows {0,1,2},{8,9,10},{16,17,18}; lines_full=3.
2. Right edge: step rd_col to 7 -> window rows {7,0,0},{15,0,0},{23,0,0}. Accepting it -> out_line_done pulses once, rd_col=0, FSM goes IDLE (only 2 lines left).
3. Backpressure: out_ready=0, stream 40 pixels -> in_ready drops after the 32nd accept; lines_full=4; out_window held at column 0. Then out_ready=1 for 8 beats -> out_line_done pulse, lines_full=3, in_ready=1 the following cycle.
4. Continuous streaming: in_valid=1, out_ready=1 -> the second output line begins {8,9,10},{16,17,18},{24,25,26} on the cycle after the last beat of line 1, with no bubble.
5. Simultaneous events: the last input pixel of a line and the last output beat are accepted in the same cycle -> lines_full unchanged, out_line_done pulses, wr_buf and rd_buf both advance.
6. Reset mid-line: assert rst during the write of line 1, column 4 -> the next cycle shows out_valid=0, lines_full=0, in_ready=1. Subsequent data is treated as line 0, and scenario 1 results repeat.

Source files
------------

// File: rtl/window_line_ctrl.sv
// Rotating line-buffer controller: stores KSIZE+1 lines of pixels and presents
// a KSIZE x KSIZE window per output beat, with ready/valid on both sides.
module window_line_ctrl #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned KSIZE   = 3,
  localparam int unsigned NUM_BUF = KSIZE + 1,
  localparam int unsigned CntW    = $clog2(NUM_BUF + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIXEL_W-1:0]               in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [KSIZE*KSIZE*PIXEL_W-1:0]   out_window,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_line_done,
  output logic [CntW-1:0]                  lines_full
);

  localparam int unsigned ColW = $clog2(LINE_W);
  localparam int unsigned BufW = $clog2(NUM_BUF);

  localparam logic [ColW-1:0] ColLast = ColW'(LINE_W - 1);
  localparam logic [BufW-1:0] BufLast = BufW'(NUM_BUF - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(NUM_BUF);
  localparam logic [CntW-1:0] CntK    = CntW'(KSIZE);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e state_q, state_d;

  logic [PIXEL_W-1:0] mem_q [NUM_BUF][LINE_W];

  logic [BufW-1:0] wr_buf_q, wr_buf_d;
  logic [BufW-1:0] rd_buf_q, rd_buf_d;
  logic [ColW-1:0] wr_col_q, wr_col_d;
  logic [ColW-1:0] rd_col_q, rd_col_d;
  logic [CntW-1:0] lines_full_q, lines_full_d;
  logic            line_done_q;

  logic in_acc;
  logic out_acc;
  logic line_complete;
  logic line_consumed;

  // in_ready depends on registered occupancy only, so the writer can never
  // reach a buffer that is still part of the active window.
  assign in_ready      = (lines_full_q < CntMax);
  assign out_valid     = (state_q == StRead);
  assign in_acc        = in_valid && in_ready;
  assign out_acc       = out_valid && out_ready;
  assign line_complete = in_acc && (wr_col_q == ColLast);
  assign line_consumed = out_acc && (rd_col_q == ColLast);
  assign lines_full    = lines_full_q;
  assign out_line_done = line_done_q;

  always_comb begin
    wr_col_d = wr_col_q;
    wr_buf_d = wr_buf_q;
    if (in_acc) begin
      if (line_complete) begin
        wr_col_d = '0;
        wr_buf_d = (wr_buf_q == BufLast) ? '0 : wr_buf_q + 1'b1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_col_d = rd_col_q;
    rd_buf_d = rd_buf_q;
    if (out_acc) begin
      if (line_consumed) begin
        rd_col_d = '0;
        rd_buf_d = (rd_buf_q == BufLast) ? '0 : rd_buf_q + 1'b1;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    lines_full_d = lines_full_q;
    unique case ({line_complete, line_consumed})
      2'b10:   lines_full_d = lines_full_q + 1'b1;
      2'b01:   lines_full_d = lines_full_q - 1'b1;
      default: lines_full_d = lines_full_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lines_full_q >= CntK) begin
          state_d = StRead;
        end
      end
      StRead: begin
        // Use next occupancy so back-to-back lines continue without a bubble.
        if (line_consumed) begin
          state_d = (lines_full_d >= CntK) ? StRead : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_buf_q     <= '0;
      wr_col_q     <= '0;
      rd_buf_q     <= '0;
      rd_col_q     <= '0;
      lines_full_q <= '0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_buf_q     <= wr_buf_d;
      wr_col_q     <= wr_col_d;
      rd_buf_q     <= rd_buf_d;
      rd_col_q     <= rd_col_d;
      lines_full_q <= lines_full_d;
      line_done_q  <= line_consumed;
    end
  end

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem_q[wr_buf_q][wr_col_q] <= in_data;
    end
  end

  always_comb begin : p_window
    logic [BufW:0]   b_sum;
    logic [BufW-1:0] b_idx;
    logic [ColW:0]   c_sum;
    b_sum      = '0;
    b_idx      = '0;
    c_sum      = '0;
    out_window = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int j = 0; j < KSIZE; j++) begin
        b_sum = {1'b0, rd_buf_q} + (BufW+1)'(r);
        b_idx = (b_sum >= (BufW+1)'(NUM_BUF)) ? BufW'(b_sum - (BufW+1)'(NUM_BUF))
                                              : b_sum[BufW-1:0];
        c_sum = {1'b0, rd_col_q} + (ColW+1)'(j);
        // Columns past the right edge read as zero instead of wrapping.
        if (c_sum < (ColW+1)'(LINE_W)) begin
          out_window[(KSIZE*KSIZE-1-(r*KSIZE+j))*PIXEL_W +: PIXEL_W] =
              mem_q[b_idx][c_sum[ColW-1:0]];
        end
      end
    end
  end

endmodule
